hi_iso14443a_tx_sched: RTL and testbench
========================================

Name: hi_iso14443a_tx_sched

Overview:
- Tag-emulation response scheduler for the HF ISO14443-A path.
- Buffers response bytes from the ARM side. Times the frame delay (FDT) from the reader's end-of-frame.
- Serialises SOF, data bits, odd parity and EOF as Manchester-coded, fc/16 on-off-keyed load modulation.
- Output drives the pwr_oe4 modulation gate; all timing is in 13.56 MHz carrier cycles.

Parameters:
- FDT_BIT0, 1172: carrier cycles from reader EOF to first tag modulation when the reader's last bit is 0.
- FDT_BIT1, 1236: same, when the reader's last bit is 1.
- FIFO_DEPTH, 4: response byte buffer entries (power of 2).
- PARITY_EN, 1: insert odd parity bit after each byte.

Ports:
- ck_1356meg  in  1  carrier clock, all logic on negedge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  tag-sim mode active; low = abort and flush
- reader_eof  in  1  one-cycle pulse, reader frame ended
- reader_last_bit  in  1  value of reader's last data bit, valid with reader_eof
- tx_data  in  8  response byte, LSB sent first
- tx_last  in  1  tx_data is final byte of frame
- tx_valid  in  1  byte offered
- tx_ready  out  1  FIFO not full
- mod_out  out  1  load modulation gate
- busy  out  1  in WAIT_FDT or transmitting
- fdt_elapsed  out  1  one-cycle pulse at FDT expiry
- underrun  out  1  sticky: FIFO ran dry mid-frame

Behaviour:
- Clocking and reset: one clock (ck_1356meg, falling edge); reset rst_n is asynchronous, active-low.
- Reset values:
  - mod_out=0, busy=0, fdt_elapsed=0, underrun=0, tx_ready=1.
  - FIFO empty, state IDLE, counters 0.
- FIFO write: a byte is accepted on any edge with tx_valid&tx_ready, in any state. Each entry is {tx_last, tx_data}.
- States:
  - IDLE: reader_eof -> WAIT_FDT. Load fdt_cnt with FDT_BIT0 or FDT_BIT1 per reader_last_bit.
  - WAIT_FDT: fdt_cnt decrements each cycle.
    - reader_eof again -> reload the counter (restart).
    - Expiry is timed so that mod_out first rises exactly FDT cycles after the edge sampling reader_eof; fdt_elapsed pulses on that same cycle.
    - At expiry, FIFO non-empty -> SOF. FIFO empty -> IDLE, with no modulation and no underrun.
  - SOF: one logic-1 bit -> DATA. Pop the first byte when entering DATA.
  - DATA: 8 bits, LSB first -> PARITY if PARITY_EN, else next byte.
  - PARITY: odd parity of the byte (bit=1 when the byte has an even number of ones).
  - Byte boundary:
    - Byte had tx_last -> EOF.
    - Else FIFO non-empty -> pop and go to DATA.
    - Else set underrun and go to EOF.
  - EOF: 128 cycles with mod_out=0 -> IDLE; busy falls on the IDLE entry edge.
- Bit timing:
  - 7-bit phase counter, 128 cycles per bit; wraps 127->0 at bit boundaries.
  - Active half: cycles 0..63 for logic 1, cycles 64..127 for logic 0.
  - mod_out = active half AND phase[3]==0, i.e. 8 on / 8 off.
  - mod_out is registered; no glitches.
- Events during transmission (SOF..EOF): reader_eof is ignored.
- enable low in any state: next edge goes to IDLE, mod_out=0, FIFO flushed, underrun kept. Writes are blocked while enable is low (tx_ready=0).
- underrun clears only on rst_n or on the next reader_eof accepted in IDLE.
- Reset mid-frame: all outputs return immediately to their reset values.

Decomposition:
- Package hi_iso14443a_pkg holds:
  - state enum: IDLE, WAIT_FDT, SOF, DATA, PARITY, EOF;
  - BIT_PERIOD=128 and SUBC_HALF=8;
  - default FDT constants.
- Sub-module iso14443a_tx_fifo: 9-bit-wide synchronous FIFO with push, pop and flush; full and empty are registered.

Test Plan:
- Basic frame: load 0x04 (tx_last=1); reader_eof with last_bit=0.
  - mod_out first rises 1172 cycles later.
  - Bit sequence: SOF=1, then 0,0,1,0,0,0,0,0, then parity=0.
  - busy falls 1172+11*128 cycles after reader_eof.
- FDT select: same frame with last_bit=1 -> first rise at 1236; fdt_elapsed is a single pulse on that cycle.
- Underrun: load 0xA5 without tx_last.
  - After the parity bit, underrun=1 and 128 idle cycles follow.
  - Then IDLE; tx_ready=1.
- Empty FIFO at expiry: fdt_elapsed pulses, mod_out stays 0 throughout, busy drops the next cycle, underrun=0.
- Retrigger: second reader_eof 500 cycles into WAIT_FDT -> first modulation 1172 cycles after the second pulse.
- Abort paths:
  - rst_n low mid-DATA -> mod_out=0 asynchronously; FIFO empty after release.
  - enable low mid-DATA -> IDLE on the next edge, FIFO flushed, tx_ready=0 while enable is low.

Source files
------------

// File: rtl/hi_iso14443a_pkg.sv
// Shared types and timing constants for the ISO14443-A tag response path.
package hi_iso14443a_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FDT,
        SOF,
        DATA,
        PARITY,
        EOF
    } tx_state_t;

    localparam int BIT_PERIOD   = 128;
    localparam int SUBC_HALF    = 8;
    localparam int FDT_BIT0_DEF = 1172;
    localparam int FDT_BIT1_DEF = 1236;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } tx_entry_t;

    // Odd parity: the appended bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/iso14443a_tx_fifo.sv
// Small show-ahead FIFO for response bytes; full/empty come straight from flops.
module iso14443a_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             do_push, do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(negedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(negedge gclk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hi_iso14443a_tx_sched.sv
// Tag-side ISO14443-A response scheduler: buffers reply bytes, waits out the
// frame delay after reader EOF, then emits Manchester/OOK subcarrier on mod_out.
module hi_iso14443a_tx_sched
    import hi_iso14443a_pkg::*;
#(
    parameter int FDT_BIT0   = FDT_BIT0_DEF,
    parameter int FDT_BIT1   = FDT_BIT1_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       reader_eof,
    input  logic       reader_last_bit,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       mod_out,
    output logic       busy,
    output logic       fdt_elapsed,
    output logic       underrun
);
    localparam int PH_W    = $clog2(BIT_PERIOD);
    localparam int SUBC_B  = $clog2(SUBC_HALF);
    localparam int FDT_MAX = (FDT_BIT1 > FDT_BIT0) ? FDT_BIT1 : FDT_BIT0;
    localparam int CNT_W   = $clog2(FDT_MAX + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_PERIOD - 1);

    tx_state_t       state, state_nxt;
    logic [PH_W-1:0] phase, phase_nxt;
    logic [CNT_W-1:0] fdt_cnt, fdt_cnt_nxt;
    logic [7:0]      cur_byte, cur_byte_nxt;
    logic            cur_last, cur_last_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic            underrun_nxt, elapsed_nxt, mod_nxt, nbit, byte_end;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    tx_entry_t       fifo_wdata, fifo_rdata;

    assign tx_ready   = enable && !fifo_full;
    assign fifo_push  = tx_valid && tx_ready;
    assign fifo_wdata = '{last: tx_last, data: tx_data};
    assign busy       = (state != IDLE);

    iso14443a_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(tx_entry_t))
    ) u_fifo (
        .gclk   (ck_1356meg),
        .grst_n (rst_n),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (!enable),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase + 1'b1;
        fdt_cnt_nxt  = fdt_cnt;
        cur_byte_nxt = cur_byte;
        cur_last_nxt = cur_last;
        bit_idx_nxt  = bit_idx;
        underrun_nxt = underrun;
        elapsed_nxt  = 1'b0;
        fifo_pop     = 1'b0;
        byte_end     = 1'b0;

        if (!enable) begin
            state_nxt   = IDLE;
            phase_nxt   = '0;
            fdt_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    phase_nxt = '0;
                    if (reader_eof) begin
                        state_nxt    = WAIT_FDT;
                        fdt_cnt_nxt  = reader_last_bit ? CNT_W'(FDT_BIT1) : CNT_W'(FDT_BIT0);
                        underrun_nxt = 1'b0;
                    end
                end
                // Expiring at 1 makes the SOF edge land exactly FDT edges after the EOF edge.
                WAIT_FDT: begin
                    phase_nxt = '0;
                    if (reader_eof) begin
                        fdt_cnt_nxt = reader_last_bit ? CNT_W'(FDT_BIT1) : CNT_W'(FDT_BIT0);
                    end else if (fdt_cnt == CNT_W'(1)) begin
                        elapsed_nxt = 1'b1;
                        fdt_cnt_nxt = '0;
                        state_nxt   = fifo_empty ? IDLE : SOF;
                    end else begin
                        fdt_cnt_nxt = fdt_cnt - 1'b1;
                    end
                end
                SOF: begin
                    if (phase == PH_LAST) begin
                        state_nxt    = DATA;
                        fifo_pop     = 1'b1;
                        cur_byte_nxt = fifo_rdata.data;
                        cur_last_nxt = fifo_rdata.last;
                        bit_idx_nxt  = '0;
                    end
                end
                DATA: begin
                    if (phase == PH_LAST) begin
                        if (bit_idx != 3'd7)
                            bit_idx_nxt = bit_idx + 3'd1;
                        else if (PARITY_EN)
                            state_nxt = PARITY;
                        else
                            byte_end = 1'b1;
                    end
                end
                PARITY: begin
                    if (phase == PH_LAST) byte_end = 1'b1;
                end
                EOF: begin
                    if (phase == PH_LAST) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            if (byte_end) begin
                if (cur_last) begin
                    state_nxt = EOF;
                end else if (!fifo_empty) begin
                    state_nxt    = DATA;
                    fifo_pop     = 1'b1;
                    cur_byte_nxt = fifo_rdata.data;
                    cur_last_nxt = fifo_rdata.last;
                    bit_idx_nxt  = '0;
                end else begin
                    state_nxt    = EOF;
                    underrun_nxt = 1'b1;
                end
            end
        end
    end

    // Modulation is computed from next-state values so the registered output is glitch-free.
    always_comb begin
        unique case (state_nxt)
            SOF:     nbit = 1'b1;
            DATA:    nbit = cur_byte_nxt[bit_idx_nxt];
            PARITY:  nbit = odd_parity(cur_byte_nxt);
            default: nbit = 1'b0;
        endcase
        mod_nxt = (state_nxt inside {SOF, DATA, PARITY}) &&
                  (phase_nxt[PH_W-1] != nbit) && !phase_nxt[SUBC_B];
    end

    always_ff @(negedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            fdt_cnt     <= '0;
            cur_byte    <= '0;
            cur_last    <= 1'b0;
            bit_idx     <= '0;
            mod_out     <= 1'b0;
            fdt_elapsed <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            fdt_cnt     <= fdt_cnt_nxt;
            cur_byte    <= cur_byte_nxt;
            cur_last    <= cur_last_nxt;
            bit_idx     <= bit_idx_nxt;
            mod_out     <= mod_nxt;
            fdt_elapsed <= elapsed_nxt;
            underrun    <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_hi_iso14443a_tx_sched.sv
// Bench for hi_iso14443a_tx_sched: frame-schedule model checked every cycle plus directed timing pins.
module tb_hi_iso14443a_tx_sched;
    localparam int FDT0  = 1172;
    localparam int FDT1  = 1236;
    localparam int DEPTH = 4;
    localparam int BP    = 128;

    logic       ck_1356meg = 1'b0;
    logic       rst_n = 1'b0, enable = 1'b1, reader_eof = 1'b0, reader_last_bit = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0, tx_valid = 1'b0;
    logic       tx_ready, mod_out, busy, fdt_elapsed, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    hi_iso14443a_tx_sched dut (
        .ck_1356meg      (ck_1356meg),
        .rst_n           (rst_n),
        .enable          (enable),
        .reader_eof      (reader_eof),
        .reader_last_bit (reader_last_bit),
        .tx_data         (tx_data),
        .tx_last         (tx_last),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .mod_out         (mod_out),
        .busy            (busy),
        .fdt_elapsed     (fdt_elapsed),
        .underrun        (underrun)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is a list of bit values laid on a 128-cycle grid from its start time.
    typedef enum {M_IDLE, M_WAIT, M_TX, M_EOF} mmode_t;
    mmode_t   mode = M_IDLE;
    bit [8:0] q[$];
    bit       bits[$];
    bit       last_flag = 1'b0;
    int       now = 0, deadline = 0, start = 0, eof_end = 0;
    bit       e_mod = 1'b0, e_busy = 1'b0, e_el = 1'b0, e_und = 1'b0;

    task automatic model_step();
        bit       acc;
        bit [8:0] ent;
        int       el, ph;
        bit       b;
        now++;
        acc  = tx_valid && enable && (q.size() < DEPTH);
        e_el = 1'b0;
        if (!enable) begin
            q.delete();
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: if (reader_eof) begin
                    mode = M_WAIT;
                    deadline = now + (reader_last_bit ? FDT1 : FDT0);
                    e_und = 1'b0;
                end
                M_WAIT: if (reader_eof) begin
                    deadline = now + (reader_last_bit ? FDT1 : FDT0);
                end else if (now == deadline) begin
                    e_el = 1'b1;
                    if (q.size() > 0) begin
                        mode = M_TX;
                        start = now;
                        bits.delete();
                        bits.push_back(1'b1);
                    end else begin
                        mode = M_IDLE;
                    end
                end
                M_TX: if (now - start == BP * bits.size()) begin
                    if (bits.size() == 1 || (!last_flag && q.size() > 0)) begin
                        ent = q.pop_front();
                        last_flag = ent[8];
                        for (int i = 0; i < 8; i++) bits.push_back(ent[i]);
                        bits.push_back(~(^ent[7:0]));
                    end else begin
                        if (!last_flag) e_und = 1'b1;
                        mode = M_EOF;
                        eof_end = now + BP;
                    end
                end
                M_EOF: if (now == eof_end) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
        if (acc) q.push_back({tx_last, tx_data});
        e_busy = (mode != M_IDLE);
        e_mod  = 1'b0;
        if (mode == M_TX) begin
            el = now - start;
            ph = el % BP;
            b  = bits[el / BP];
            e_mod = (b ? (ph < BP/2) : (ph >= BP/2)) && ((ph / 8) % 2 == 0);
        end
    endtask

    initial forever begin
        @(negedge ck_1356meg or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            bits.delete();
            mode = M_IDLE;
            e_mod = 1'b0; e_busy = 1'b0; e_el = 1'b0; e_und = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(posedge ck_1356meg) begin
        if (rst_n) begin
            chk("cyc mod_out", mod_out, e_mod);
            chk("cyc busy", busy, e_busy);
            chk("cyc fdt_elapsed", fdt_elapsed, e_el);
            chk("cyc underrun", underrun, e_und);
            chk("cyc tx_ready", tx_ready, int'(enable && (q.size() < DEPTH)));
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic l);
        @(posedge ck_1356meg); #2;
        tx_valid = 1'b1; tx_data = d; tx_last = l;
        @(posedge ck_1356meg); #2;
        tx_valid = 1'b0;
    endtask

    task automatic pulse_eof(input logic lb);
        @(posedge ck_1356meg); #2;
        reader_eof = 1'b1; reader_last_bit = lb;
        @(posedge ck_1356meg); #2;
        reader_eof = 1'b0;
    endtask

    // Cycle counts are edges after the edge that sampled reader_eof.
    task automatic run_frame(input logic lb, output int rise, output int fall,
                             output int el_at, output int el_cnt, output logic [9:0] seq);
        int n;
        rise = -1; fall = -1; el_at = -1; el_cnt = 0; seq = '0; n = 0;
        pulse_eof(lb);
        while (fall < 0 && n < 6000) begin
            @(negedge ck_1356meg); n++; #1;
            if (fdt_elapsed) begin
                el_cnt++;
                if (el_at < 0) el_at = n;
            end
            if (mod_out && rise < 0) rise = n;
            if (rise >= 0 && (n - rise) % BP == 0 && (n - rise) / BP < 10)
                seq[(n - rise) / BP] = mod_out;
            if (!busy) fall = n;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, fall, el_at, el_cnt;
        logic [9:0] seq;

        repeat (3) @(posedge ck_1356meg);
        #2 rst_n = 1'b1;
        @(negedge ck_1356meg); #1;
        chk("reset mod_out", mod_out, 0);
        chk("reset busy", busy, 0);
        chk("reset fdt_elapsed", fdt_elapsed, 0);
        chk("reset underrun", underrun, 0);
        chk("reset tx_ready", tx_ready, 1);

        // Basic frame, last bit 0
        push_byte(8'h04, 1'b1);
        run_frame(1'b0, rise, fall, el_at, el_cnt, seq);
        chk("basic first rise", rise, 1172);
        chk("basic elapsed cycle", el_at, 1172);
        chk("basic bit sequence", int'(seq), 10'h009);
        chk("basic busy fall", fall, 1172 + 11*128);
        chk("basic underrun", underrun, 0);

        // FDT select, last bit 1
        push_byte(8'h04, 1'b1);
        run_frame(1'b1, rise, fall, el_at, el_cnt, seq);
        chk("fdt1 first rise", rise, 1236);
        chk("fdt1 elapsed cycle", el_at, 1236);
        chk("fdt1 elapsed pulses", el_cnt, 1);
        chk("fdt1 busy fall", fall, 1236 + 11*128);

        // Underrun: no tx_last
        push_byte(8'hA5, 1'b0);
        run_frame(1'b0, rise, fall, el_at, el_cnt, seq);
        chk("underrun bit sequence", int'(seq), 10'h34B);
        chk("underrun busy fall", fall, 1172 + 11*128);
        chk("underrun flag", underrun, 1);
        chk("underrun tx_ready", tx_ready, 1);

        // Empty FIFO at expiry; also clears underrun
        run_frame(1'b0, rise, fall, el_at, el_cnt, seq);
        chk("empty elapsed cycle", el_at, 1172);
        chk("empty no modulation", rise, -1);
        chk("empty busy fall", fall, 1172);
        chk("empty underrun cleared", underrun, 0);

        // Retrigger during WAIT_FDT
        push_byte(8'h04, 1'b1);
        pulse_eof(1'b0);
        repeat (500) @(posedge ck_1356meg);
        run_frame(1'b0, rise, fall, el_at, el_cnt, seq);
        chk("retrigger first rise", rise, 1172);
        chk("retrigger elapsed pulses", el_cnt, 1);

        // Async reset mid-DATA
        push_byte(8'h04, 1'b0);
        push_byte(8'h04, 1'b1);
        pulse_eof(1'b0);
        repeat (1172 + 3*128 + 2) @(negedge ck_1356meg);
        #1 chk("pre-reset mod_out", mod_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset mod_out", mod_out, 0);
        chk("async reset busy", busy, 0);
        chk("async reset tx_ready", tx_ready, 1);
        @(posedge ck_1356meg); #2 rst_n = 1'b1;
        run_frame(1'b0, rise, fall, el_at, el_cnt, seq);
        chk("post-reset fifo empty", rise, -1);
        chk("post-reset busy fall", fall, 1172);

        // enable low mid-DATA
        push_byte(8'h04, 1'b0);
        push_byte(8'h04, 1'b1);
        pulse_eof(1'b0);
        repeat (1172 + 3*128 + 2) @(negedge ck_1356meg);
        #3;
        enable = 1'b0; tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
        #1 chk("disable tx_ready", tx_ready, 0);
        @(negedge ck_1356meg); #1;
        chk("disable busy", busy, 0);
        chk("disable mod_out", mod_out, 0);
        chk("disable tx_ready held", tx_ready, 0);
        @(posedge ck_1356meg); #2;
        tx_valid = 1'b0; enable = 1'b1;
        run_frame(1'b0, rise, fall, el_at, el_cnt, seq);
        chk("disable flushed", rise, -1);
        chk("disable busy fall", fall, 1172);

        // Randomized traffic against the model
        begin
            int dens = 0;
            for (int c = 0; c < 30000; c++) begin
                @(posedge ck_1356meg); #2;
                if (c % 2000 == 0) dens = $urandom_range(0, 2);
                tx_valid = ($urandom_range(0, (dens == 0) ? 1 : (dens == 1) ? 100 : 600) == 0);
                tx_data  = 8'($urandom);
                tx_last  = ($urandom_range(0, 2) == 0);
                reader_eof      = ($urandom_range(0, 799) == 0);
                reader_last_bit = 1'($urandom);
                if (enable && $urandom_range(0, 7999) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
            end
            @(posedge ck_1356meg); #2;
            tx_valid = 1'b0; reader_eof = 1'b0; enable = 1'b1;
            repeat (3000) @(posedge ck_1356meg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
